// File: rtl/lfsr_match_monitor.sv
// Observer for the 6-bit LFSR stage: counts enabled steps to count_to, flags timeout.
// Optional all-zero lockup detection is compiled in with LFSR_LOCKUP_DETECT_EN.
module lfsr_match_monitor #(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] lfsr_q,
   input  logic             load,
   input  logic             cen,
   input  logic [WIDTH-1:0] count_to,
   output logic             match,
   output logic [WIDTH-1:0] steps,
   output logic             busy,
   output logic             timeout,
   output logic             lockup
);

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      HIT,
      STOP
   } state_t;

   localparam logic [WIDTH-1:0] CNT_MAX = '1;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] steps_d;
   logic             match_d;
   logic             timeout_d;
`ifdef LFSR_LOCKUP_DETECT_EN
   logic             lockup_d;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         steps   <= '0;
         match   <= 1'b0;
         busy    <= 1'b0;
         timeout <= 1'b0;
`ifdef LFSR_LOCKUP_DETECT_EN
         lockup  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         steps   <= steps_d;
         match   <= match_d;
         busy    <= (state_d == ARMED);
         timeout <= timeout_d;
`ifdef LFSR_LOCKUP_DETECT_EN
         lockup  <= lockup_d;
`endif
      end
   end

   // Load dominates everything, including a compare that is true on the same edge.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      steps_d   = steps;
      match_d   = 1'b0;
      timeout_d = timeout;
`ifdef LFSR_LOCKUP_DETECT_EN
      lockup_d  = lockup;
`endif
      if (load) begin
         state_d   = ARMED;
         cnt_d     = '0;
         steps_d   = '0;
         timeout_d = 1'b0;
`ifdef LFSR_LOCKUP_DETECT_EN
         lockup_d  = 1'b0;
`endif
      end else if (state_q == ARMED) begin
         if (lfsr_q == count_to) begin
            match_d = 1'b1;
            steps_d = cnt_q;
            state_d = HIT;
         end
`ifdef LFSR_LOCKUP_DETECT_EN
         else if (cen && (lfsr_q == '0)) begin
            lockup_d = 1'b1;
            state_d  = STOP;
         end
`endif
         else if (cen && (cnt_q == CNT_MAX)) begin
            timeout_d = 1'b1;
            state_d   = STOP;
         end else if (cen) begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

`ifndef LFSR_LOCKUP_DETECT_EN
   assign lockup = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_match_monitor.sv
// Bench for lfsr_match_monitor: vector table driven through an LFSR model,
// plus hand-written timeout, saturation, reset and lockup sequences.
module tb_lfsr_match_monitor;

   logic       clk = 1'b0;
   logic       reset;
   logic       load;
   logic       cen;
   logic [5:0] lfsr_q;
   logic [5:0] count_to;
   logic       match;
   logic [5:0] steps;
   logic       busy;
   logic       timeout;
   logic       lockup;

   lfsr_match_monitor #(.WIDTH(6)) dut (
      .clk      (clk),
      .reset    (reset),
      .lfsr_q   (lfsr_q),
      .load     (load),
      .cen      (cen),
      .count_to (count_to),
      .match    (match),
      .steps    (steps),
      .busy     (busy),
      .timeout  (timeout),
      .lockup   (lockup)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       ld;
      logic       c;
      logic [5:0] seed;
      logic [5:0] ct;
      logic [9:0] exp;
   } vec_t;

   localparam logic [5:0] T = 6'b010000;
   localparam logic [5:0] U = 6'b000001;

   vec_t       tbl[25];
   logic [9:0] sb[$];
   logic [5:0] lq;
   int         pass_cnt = 0;
   int         total_cnt = 0;

   // Bench LFSR: shift right, feedback q0^q2^q3^q4; 001011 reaches 010000 in 5 steps
   function automatic logic [5:0] lfsr_nxt(input logic [5:0] q);
      return {q[0] ^ q[2] ^ q[3] ^ q[4], q[5:1]};
   endfunction

   function automatic logic [9:0] ev(input int m, input int s, input int b,
                                     input int t, input int l);
      return {m[0], s[5:0], b[0], t[0], l[0]};
   endfunction

   function automatic logic [9:0] outv();
      return {match, steps, busy, timeout, lockup};
   endfunction

   task automatic check(input string name, input logic [9:0] act,
                        input logic [9:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %b required %b ({match,steps,busy,timeout,lockup})",
                    name, act, exp);
   endtask

   task automatic cyc(input string name, input logic ld, input logic c,
                      input logic [5:0] q, input logic [5:0] ct,
                      input logic [9:0] exp);
      logic [9:0] e;
      @(negedge clk);
      load = ld;
      cen = c;
      lfsr_q = q;
      count_to = ct;
      sb.push_back(exp);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check(name, outv(), e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tbl[0]  = '{1'b1, 1'b0, 6'b001011, T, ev(0, 0, 1, 0, 0)};
      for (int i = 1; i <= 5; i++)
         tbl[i] = '{1'b0, 1'b1, 6'd0, T, ev(0, 0, 1, 0, 0)};
      tbl[6]  = '{1'b0, 1'b1, 6'd0, T, ev(1, 5, 0, 0, 0)};
      tbl[7]  = '{1'b0, 1'b1, 6'd0, T, ev(0, 5, 0, 0, 0)};
      tbl[8]  = '{1'b1, 1'b0, T, T, ev(0, 0, 1, 0, 0)};
      tbl[9]  = '{1'b0, 1'b1, 6'd0, T, ev(1, 0, 0, 0, 0)};
      tbl[10] = '{1'b1, 1'b0, 6'b000010, U, ev(0, 0, 1, 0, 0)};
      tbl[11] = '{1'b0, 1'b1, 6'd0, U, ev(0, 0, 1, 0, 0)};
      tbl[12] = '{1'b1, 1'b1, 6'b000010, U, ev(0, 0, 1, 0, 0)};
      tbl[13] = '{1'b0, 1'b1, 6'd0, U, ev(0, 0, 1, 0, 0)};
      tbl[14] = '{1'b0, 1'b0, 6'd0, U, ev(1, 1, 0, 0, 0)};
      tbl[15] = '{1'b1, 1'b0, 6'b000010, T, ev(0, 0, 1, 0, 0)};
      tbl[16] = '{1'b0, 1'b0, 6'd0, T, ev(0, 0, 1, 0, 0)};
      tbl[17] = '{1'b0, 1'b1, 6'd0, T, ev(0, 0, 1, 0, 0)};
      tbl[18] = '{1'b0, 1'b0, 6'd0, T, ev(0, 0, 1, 0, 0)};
      tbl[19] = '{1'b0, 1'b0, 6'd0, T, ev(0, 0, 1, 0, 0)};
      tbl[20] = '{1'b0, 1'b1, 6'd0, T, ev(0, 0, 1, 0, 0)};
      tbl[21] = '{1'b0, 1'b0, 6'd0, T, ev(0, 0, 1, 0, 0)};
      tbl[22] = '{1'b0, 1'b1, 6'd0, T, ev(0, 0, 1, 0, 0)};
      tbl[23] = '{1'b0, 1'b0, 6'd0, T, ev(1, 3, 0, 0, 0)};
      tbl[24] = '{1'b0, 1'b1, 6'd0, T, ev(0, 3, 0, 0, 0)};

      reset = 1'b1;
      load = 1'b0;
      cen = 1'b0;
      lfsr_q = '0;
      count_to = '0;
      lq = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", outv(), ev(0, 0, 0, 0, 0));
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 25; i++) begin
         cyc($sformatf("vec%0d", i), tbl[i].ld, tbl[i].c, lq, tbl[i].ct, tbl[i].exp);
         if (tbl[i].ld) lq = tbl[i].seed;
         else if (tbl[i].c) lq = lfsr_nxt(lq);
      end

      cyc("to_load", 1'b1, 1'b0, 6'h01, 6'h3F, ev(0, 0, 1, 0, 0));
      for (int i = 0; i < 63; i++)
         cyc("to_run", 1'b0, 1'b1, 6'(i % 62 + 1), 6'h3F, ev(0, 0, 1, 0, 0));
      cyc("to_hit", 1'b0, 1'b1, 6'h05, 6'h3F, ev(0, 0, 0, 1, 0));
      cyc("to_stop", 1'b0, 1'b1, 6'h3F, 6'h3F, ev(0, 0, 0, 1, 0));
      cyc("to_clear", 1'b1, 1'b0, 6'h01, 6'h3F, ev(0, 0, 1, 0, 0));

      for (int i = 0; i < 63; i++)
         cyc("max_run", 1'b0, 1'b1, 6'(i % 62 + 1), 6'h3F, ev(0, 0, 1, 0, 0));
      cyc("max_steps", 1'b0, 1'b1, 6'h3F, 6'h3F, ev(1, 63, 0, 0, 0));

      cyc("rst_load", 1'b1, 1'b0, 6'h01, T, ev(0, 0, 1, 0, 0));
      for (int i = 1; i <= 4; i++)
         cyc("rst_run", 1'b0, 1'b1, 6'(i), T, ev(0, 0, 1, 0, 0));
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst_async", outv(), ev(0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      check("rst_held", outv(), ev(0, 0, 0, 0, 0));
      @(negedge clk);
      reset = 1'b0;
      cyc("rst_idle0", 1'b0, 1'b1, T, T, ev(0, 0, 0, 0, 0));
      cyc("rst_idle1", 1'b0, 1'b1, T, T, ev(0, 0, 0, 0, 0));

`ifdef LFSR_LOCKUP_DETECT_EN
      cyc("lk_load", 1'b1, 1'b0, 6'h01, T, ev(0, 0, 1, 0, 0));
      cyc("lk_zero", 1'b0, 1'b1, 6'h00, T, ev(0, 0, 0, 0, 1));
      cyc("lk_stop", 1'b0, 1'b1, T, T, ev(0, 0, 0, 0, 1));
      cyc("lk_clear", 1'b1, 1'b0, 6'h01, T, ev(0, 0, 1, 0, 0));
`else
      cyc("zero_load", 1'b1, 1'b0, 6'h01, T, ev(0, 0, 1, 0, 0));
      cyc("zero_step", 1'b0, 1'b1, 6'h00, T, ev(0, 0, 1, 0, 0));
      cyc("zero_hit", 1'b0, 1'b0, T, T, ev(1, 1, 0, 0, 0));
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/lfsr_match_monitor.md
# lfsr_match_monitor

Downstream observer for the 6-bit LFSR counter stage. It sees the LFSR's registered state and the same `load`/`cen` controls that drive the LFSR. It counts the enabled steps taken since the last load, pulses `match` when the state equals `count_to`, and latches the step count. It flags a timeout when the target cannot be reached within one maximal period.

## Interface
- `WIDTH`, 6, LFSR state width; also the width of the step counter.
- `clk`  in  1  rising-edge clock shared with the LFSR.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `lfsr_q`  in  WIDTH  current registered LFSR state.
- `load`  in  1  LFSR load strobe; the LFSR takes its seed on any edge where this is high.
- `cen`  in  1  LFSR count enable; the LFSR advances on edges with `cen`=1 and `load`=0.
- `count_to`  in  WIDTH  target state; compared live every cycle.
- `match`  out  1  one-cycle pulse, target reached.
- `steps`  out  WIDTH  step count latched at match; holds until the next load or reset.
- `busy`  out  1  high while in ARMED.
- `timeout`  out  1  sticky; target not reached within 2^WIDTH−1 steps.
- `lockup`  out  1  sticky; all-zero LFSR state detected (see Configuration).

## Operation
- FSM states:
  - IDLE: reset state.
  - ARMED: counting.
  - HIT: target found; holds until the next load.
  - STOP: terminal after timeout or lockup.
- `load`=1 on any edge, in any state:
  - go to ARMED;
  - `step_cnt`←0;
  - clear `steps`, `timeout`, `lockup`;
  - no match is evaluated on that edge.
- Edge evaluation in ARMED with `load`=0, in priority order:
  - `lfsr_q`==`count_to`: `match`←1, `steps`←`step_cnt`, go to HIT.
  - Lockup condition (macro on): `lockup`←1, go to STOP.
  - `cen`=1 and `step_cnt`==2^WIDTH−1: `timeout`←1, go to STOP.
  - `cen`=1 otherwise: `step_cnt`←`step_cnt`+1.
  - `cen`=0: hold.
- `step_cnt` is unsigned WIDTH bits and never wraps; the saturation point is the timeout condition.
- HIT, STOP and IDLE ignore `cen` and `lfsr_q`. Only `load` or `reset` leaves them.
- A change to `count_to` mid-run takes effect at the next edge.
- `busy` = (state==ARMED), registered.

## Timing
- Reset values: `match`=0, `steps`=0, `busy`=0, `timeout`=0, `lockup`=0, state IDLE. Assertion is asynchronous; release is synchronous to `clk`.
- Seed timing: the seed is visible on `lfsr_q` in the cycle after the load edge, with `step_cnt`=0. A seed equal to `count_to` gives `match` at the first edge after load, with `steps`=0.
- Match latency: `match`, `steps` and `busy`=0 update on the edge that samples `lfsr_q`==`count_to`. All outputs are registered, so there is no combinational path from input to output.
- `match` is high for exactly one cycle.
- Simultaneous `load` and a true compare: load wins, no match.
- Reset mid-ARMED aborts the run with no `match` pulse.
- Maximum reportable `steps` = 2^WIDTH−1 (63).

## Configuration
- `LFSR_LOCKUP_DETECT_EN` defined:
  - In ARMED with `load`=0, `cen`=1 and `lfsr_q`==0 (and not a match), set `lockup` and go to STOP.
- Undefined:
  - `lockup` is tied to 0.
  - An all-zero state counts as normal steps and ends in `timeout` unless it matches.

## Test plan
- Reset: assert `reset` mid-run with `step_cnt`=4 → all outputs 0 asynchronously, state IDLE, and no `match` after release.
- Normal hit:
  - Stimulus: `load` with seed 6'b001011, `count_to`=6'b010000; the bench LFSR model reaches the target after 5 enabled steps.
  - Required: single-cycle `match`, `steps`=5, `busy` falls the same edge.
- Seed equals target: seed 6'b010000, `count_to`=6'b010000 → `match` at the first edge after load, `steps`=0.
- `cen` gaps: 3 enabled steps interleaved with 4 `cen`=0 cycles before the target → `steps`=3, no early match.
- Load priority: `load`=1 on the edge where `lfsr_q`==`count_to` → no `match`, state ARMED, `step_cnt`=0.
- Unreachable target (macro undefined): bench drives 63 enabled non-matching states → `timeout`=1 on the 64th enabled edge, `busy`=0, `match` never. A following `load` clears `timeout`.
- Lockup (macro defined): drive `lfsr_q`=0 with `cen`=1 in ARMED → `lockup`=1 the same edge, state STOP, `busy`=0.
